// File: rtl/serial_subtractor_pkg.sv
// Shared arithmetic-library package for the serial subtractor.
//   sub_state_t   : controller states (IDLE, SHIFT, DONE)
//   SUB_WIDTH_DEF : default operand/result width
package arith_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } sub_state_t;

  localparam int unsigned SUB_WIDTH_DEF = 4;

endpackage : arith_pkg

// File: rtl/serial_subtractor_if.sv
// Request/response bundle of the serial subtractor.
//   start/a/b/bin : requester -> subtractor (sampled on the accepting edge)
//   ready/busy    : subtractor status
//   done/d/bout   : result strobe and held result
//   ovf           : signed overflow, present only with SERIAL_SUB_OVF_EN
// The master modport is the requester/consumer side, slave is the subtractor.
interface serial_subtractor_if #(
  parameter int unsigned WIDTH = arith_pkg::SUB_WIDTH_DEF
);

  logic             start;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             bin;
  logic             ready;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] d;
  logic             bout;
`ifdef SERIAL_SUB_OVF_EN
  logic             ovf;
`endif

  modport master (
    output start, a, b, bin,
`ifdef SERIAL_SUB_OVF_EN
    input  ovf,
`endif
    input  ready, busy, done, d, bout
  );

  modport slave (
    input  start, a, b, bin,
`ifdef SERIAL_SUB_OVF_EN
    output ovf,
`endif
    output ready, busy, done, d, bout
  );

endinterface : serial_subtractor_if

// File: rtl/serial_subtractor_full_subtractor.sv
// Single-bit full subtractor: x - y - bi.
//   x, y, bi : minuend bit, subtrahend bit, borrow-in
//   diff     : difference bit
//   bo       : borrow-out
module full_subtractor (
  input  logic x,
  input  logic y,
  input  logic bi,
  output logic diff,
  output logic bo
);

  always_comb begin
    diff = x ^ y ^ bi;
    bo   = (~x & y) | (~(x ^ y) & bi);
  end

endmodule : full_subtractor

// File: rtl/serial_subtractor.sv
// Bit-serial LSB-first subtractor: D = A - B - Bin over WIDTH cycles using
// one full-subtractor cell and a borrow flop.
//   clk   : rising-edge clock
//   rst_n : asynchronous active-low reset
//   bus   : serial_subtractor_if slave (start/a/b/bin in; ready/busy/done/d/bout out)
// Optional macro SERIAL_SUB_OVF_EN adds bus.ovf (two's-complement overflow).
module serial_subtractor
  import arith_pkg::*;
#(
  parameter int unsigned WIDTH = SUB_WIDTH_DEF
) (
  input  logic                clk,
  input  logic                rst_n,
  serial_subtractor_if.slave  bus
);

  localparam int unsigned CW = $clog2(WIDTH) + 1;

  sub_state_t       state, state_nx;

  logic [WIDTH-1:0] a_sh;
  logic [WIDTH-1:0] b_sh;
  logic [WIDTH-1:0] d_r;
  logic             brw;
  logic             bout_r;
  logic [CW-1:0]    cnt;

  logic             load;
  logic             step;
  logic             last;
  logic             ready_c;
  logic             busy_c;
  logic             done_c;
  logic             diff;
  logic             nb;

  full_subtractor u_fs (
    .x    (a_sh[0]),
    .y    (b_sh[0]),
    .bi   (brw),
    .diff (diff),
    .bo   (nb)
  );

  assign last = (cnt == CW'(WIDTH - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nx;
  end

  // DONE accepts start exactly like IDLE so results can be issued back-to-back.
  always_comb begin
    state_nx = state;
    load     = 1'b0;
    step     = 1'b0;
    ready_c  = 1'b0;
    busy_c   = 1'b0;
    done_c   = 1'b0;
    unique case (state)
      IDLE: begin
        ready_c = 1'b1;
        if (bus.start) begin
          load     = 1'b1;
          state_nx = SHIFT;
        end
      end
      SHIFT: begin
        busy_c = 1'b1;
        step   = 1'b1;
        if (last) state_nx = DONE;
      end
      DONE: begin
        ready_c = 1'b1;
        done_c  = 1'b1;
        if (bus.start) begin
          load     = 1'b1;
          state_nx = SHIFT;
        end else begin
          state_nx = IDLE;
        end
      end
      default: state_nx = IDLE;
    endcase
  end

  // Difference bits enter at the MSB and move down, so after WIDTH steps
  // the first (LSB) result bit has reached d_r[0].
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_sh   <= '0;
      b_sh   <= '0;
      d_r    <= '0;
      brw    <= 1'b0;
      bout_r <= 1'b0;
      cnt    <= '0;
    end else if (load) begin
      a_sh   <= bus.a;
      b_sh   <= bus.b;
      brw    <= bus.bin;
      cnt    <= '0;
      d_r    <= '0;
      bout_r <= 1'b0;
    end else if (step) begin
      d_r  <= {diff, d_r[WIDTH-1:1]};
      a_sh <= a_sh >> 1;
      b_sh <= b_sh >> 1;
      brw  <= nb;
      cnt  <= cnt + CW'(1);
      if (last) bout_r <= nb;
    end
  end

`ifdef SERIAL_SUB_OVF_EN
  logic ovf_r;

  // On the last step a_sh[0]/b_sh[0] hold the operand MSBs and diff is the result MSB.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ovf_r <= 1'b0;
    end else if (load) begin
      ovf_r <= 1'b0;
    end else if (step && last) begin
      ovf_r <= (a_sh[0] ^ b_sh[0]) & (a_sh[0] ^ diff);
    end
  end

  assign bus.ovf = ovf_r;
`endif

  assign bus.ready = ready_c;
  assign bus.busy  = busy_c;
  assign bus.done  = done_c;
  assign bus.d     = d_r;
  assign bus.bout  = bout_r;

endmodule : serial_subtractor

// File: tb/tb_serial_subtractor.sv
module tb_serial_subtractor;

  localparam int unsigned W = 4;

  typedef struct {
    logic [W-1:0] d;
    logic         bout;
    logic         ovf;
    int           cyc;
  } exp_t;

  logic clk;
  logic rst_n;
  int   cyc;
  int   checks;
  int   passed;
  exp_t q[$];

  serial_subtractor_if #(.WIDTH(W)) bus ();

  serial_subtractor #(.WIDTH(W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk or negedge rst_n)
    if (!rst_n) cyc <= 0;
    else        cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %0d expected %0d", name, act, exp);
  endtask

  // Monitor: every done must match the oldest outstanding expectation.
  always @(negedge clk) begin
    if (rst_n && bus.done) begin
      if (q.size() == 0) begin
        chk("unexpected_done", 1, 0);
      end else begin
        exp_t e;
        e = q.pop_front();
        chk("d", bus.d, e.d);
        chk("bout", bus.bout, e.bout);
        chk("done_cycle", cyc, e.cyc);
        chk("ready_at_done", bus.ready, 1);
`ifdef SERIAL_SUB_OVF_EN
        chk("ovf", bus.ovf, e.ovf);
`endif
      end
    end
  end

  // Caller positions at a negedge; returns #1 after the edge that samples start.
  task automatic issue(input logic [W-1:0] a, input logic [W-1:0] b, input logic bin,
                       input logic [W-1:0] ed, input logic eb, input logic eo,
                       input bit accepted);
    exp_t e;
    bus.a = a; bus.b = b; bus.bin = bin; bus.start = 1'b1;
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    bus.a = '1; bus.b = '1; bus.bin = 1'b1;
    if (accepted) begin
      e.d = ed; e.bout = eb; e.ovf = eo; e.cyc = cyc + W;
      q.push_back(e);
    end
  endtask

  // Returns at the negedge where done is seen (or after a bounded wait).
  task automatic wait_done(input string name);
    int k;
    k = 0;
    @(negedge clk);
    while (!bus.done && k < 30) begin
      @(negedge clk);
      k++;
    end
    if (!bus.done) chk({name, "_timeout"}, 0, 1);
  endtask

  initial begin
    checks = 0; passed = 0;
    bus.start = 1'b0; bus.a = '0; bus.b = '0; bus.bin = 1'b0;
    rst_n = 1'b0;
    #1;
    chk("rst_ready", bus.ready, 1);
    chk("rst_busy", bus.busy, 0);
    chk("rst_done", bus.done, 0);
    chk("rst_d", bus.d, 0);
    chk("rst_bout", bus.bout, 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    // Basic vectors
    @(negedge clk); issue(4'd5,  4'd3,  1'b0, 4'b0010, 1'b0, 1'b0, 1);
    chk("busy_in_shift", bus.busy, 1);
    chk("ready_in_shift", bus.ready, 0);
    wait_done("v5m3");
    @(negedge clk); issue(4'd3,  4'd5,  1'b0, 4'b1110, 1'b1, 1'b0, 1); wait_done("v3m5");
    @(negedge clk); issue(4'd15, 4'd15, 1'b1, 4'b1111, 1'b1, 1'b0, 1); wait_done("v15m15b");
    @(negedge clk); issue(4'd0,  4'd0,  1'b0, 4'b0000, 1'b0, 1'b0, 1); wait_done("v0m0");

    // Start while busy is ignored; start during DONE is accepted back-to-back
    @(negedge clk); issue(4'd6, 4'd2, 1'b0, 4'b0100, 1'b0, 1'b0, 1);
    @(negedge clk);
    @(negedge clk); issue(4'd9, 4'd1, 1'b0, 4'b0000, 1'b0, 1'b0, 0);
    wait_done("v6m2");
    issue(4'd9, 4'd1, 1'b0, 4'b1000, 1'b0, 1'b0, 1);
    wait_done("v9m1_b2b");

    // Reset during SHIFT aborts without a done
    @(negedge clk); issue(4'd12, 4'd5, 1'b0, 4'b0000, 1'b0, 1'b0, 0);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("abort_ready", bus.ready, 1);
    chk("abort_busy", bus.busy, 0);
    chk("abort_done", bus.done, 0);
    chk("abort_d", bus.d, 0);
    chk("abort_bout", bus.bout, 0);
    repeat (6) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk); issue(4'd8, 4'd8, 1'b0, 4'b0000, 1'b0, 1'b0, 1); wait_done("v8m8");

    // Signed-overflow boundary vectors
    @(negedge clk); issue(4'b0111, 4'b1000, 1'b0, 4'b1111, 1'b1, 1'b1, 1); wait_done("v7m8");
    @(negedge clk); issue(4'b0110, 4'b0001, 1'b0, 4'b0101, 1'b0, 1'b0, 1); wait_done("v6m1");

`ifdef SERIAL_SUB_OVF_EN
    for (int i = 0; i < 16; i++) begin
      for (int j = 0; j < 16; j++) begin
        for (int c = 0; c < 2; c++) begin
          int sa, sb, r;
          logic [W-1:0] ed;
          sa = (i >= 8) ? i - 16 : i;
          sb = (j >= 8) ? j - 16 : j;
          r  = sa - sb - c;
          ed = W'((i - j - c) & 15);
          @(negedge clk);
          issue(W'(i), W'(j), c[0], ed, (i < j + c), (r < -8 || r > 7), 1);
          wait_done("sweep");
        end
      end
    end
`endif

    begin
      int k;
      k = 0;
      while (q.size() != 0 && k < 50) begin
        @(negedge clk);
        k++;
      end
    end
    chk("queue_drained", q.size(), 0);
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule : tb_serial_subtractor

// File: doc/serial_subtractor.md
Name: serial_subtractor

Overview:
- Bit-serial, LSB-first subtractor: computes D = A - B - Bin over WIDTH clock cycles using one full-subtractor cell and a borrow flip-flop.
- Counterpart to the parallel adder in the arithmetic library.
- Sits between a requester, which presents operands with a start pulse, and a consumer, which samples the result on done.
- Trades latency for area relative to a ripple array.

Parameters:
- WIDTH, 4, operand and result width in bits (legal range 2..16).

Ports:
- clk  input  1  system clock, rising-edge active
- rst_n  input  1  asynchronous active-low reset
- start  input  1  request; accepted only when ready=1
- a  input  WIDTH  minuend, sampled on the accepting edge
- b  input  WIDTH  subtrahend, sampled on the accepting edge
- bin  input  1  borrow-in, sampled on the accepting edge
- ready  output  1  block can accept start (IDLE or DONE)
- busy  output  1  subtraction in progress (SHIFT)
- done  output  1  one-cycle pulse; d/bout valid
- d  output  WIDTH  difference, held until next accepted start
- bout  output  1  borrow-out (1 = A < B + Bin, unsigned)

Behaviour:
- Reset is asynchronous, active-low: clk and rst_n; rst_n low acts immediately, independent of clk.
- Reset values:
  - state=IDLE, ready=1, busy=0, done=0, d=0, bout=0.
  - Internal shift registers, borrow flop and counter are all 0.
- States: IDLE, SHIFT, DONE.
- IDLE:
  - ready=1.
  - start=1 on an edge: load a_sh<=a, b_sh<=b, brw<=bin, cnt<=0, d<=0, bout<=0, then go to SHIFT.
- SHIFT (busy=1, ready=0), each edge:
  - diff = a_sh[0]^b_sh[0]^brw; nb = (~a_sh[0]&b_sh[0]) | (~(a_sh[0]^b_sh[0])&brw).
  - d <= {diff, d[WIDTH-1:1]}; a_sh, b_sh shift right by one; brw<=nb; cnt<=cnt+1.
  - When cnt==WIDTH-1, also bout<=nb and go to DONE.
- DONE:
  - done=1 for exactly this cycle; ready=1.
  - start=1 here is accepted exactly as in IDLE and goes to SHIFT (back-to-back operation).
  - Otherwise go to IDLE.
- Latency: start accepted on edge N; done high in the cycle after edge N+WIDTH. Throughput is one result per WIDTH+1 cycles.
- start while busy=1 is ignored: no queueing, and operands are not resampled.
- Operand inputs are don't-care except on the accepting edge.
- d and bout:
  - Change only during SHIFT.
  - Are stable from done until the next accepting edge.
  - Carry intermediate (partial) values while busy.
- Arithmetic is modulo 2^WIDTH: d = (a - b - bin) mod 2^WIDTH; bout = (a < b + bin).
- cnt width is $clog2(WIDTH)+1 bits. No wrap hazard, since cnt is reloaded on every accept.
- Reset mid-operation aborts immediately to reset values. No done is produced for the aborted operation.

Optional Feature:
- Macro: SERIAL_SUB_OVF_EN.
- With the macro defined:
  - Adds output ovf (1 bit), reset 0, cleared on the accepting edge.
  - ovf is set on the last SHIFT edge to (a_msb ^ b_msb) & (a_msb ^ diff_msb), where a_msb and b_msb are the operand MSBs being consumed that cycle.
  - This is the two's-complement signed overflow of a - b - bin. It is valid and held exactly like d.
- Without the macro: port ovf does not exist and the associated logic is absent. All other behaviour is identical.

Decomposition:
- Shared package arith_pkg:
  - State enum sub_state_t {IDLE, SHIFT, DONE}.
  - Localparam for the default width (4).
- Natural sub-module: full_subtractor (inputs x, y, bi; outputs diff, bo), purely combinational, instantiated once.

Test Plan:
- a=5, b=3, bin=0, start -> done in the cycle after edge +4; d=0010, bout=0.
- a=3, b=5, bin=0 -> d=1110, bout=1.
- a=15, b=15, bin=1 -> d=1111, bout=1. Separately, a=0, b=0, bin=0 -> d=0000, bout=0.
- Pulse start again with a=9, b=1 two cycles after a first start (a=6, b=2):
  - Second start is ignored; result is d=0100.
  - Then a start asserted during the DONE cycle with a=9, b=1 is accepted; result is d=1000 with no IDLE gap.
- Drop rst_n at SHIFT cycle 2 -> outputs return to reset values immediately; done never pulses for that operation. After release, a new start (a=8, b=8) yields d=0000, bout=0.
- With SERIAL_SUB_OVF_EN:
  - a=0111, b=1000 -> d=1111, bout=1, ovf=1.
  - a=0110, b=0001 -> ovf=0.
  - Exhaustive 16x16 sweep with bin=0 and bin=1 checks d, bout and ovf against a reference model.
